atm_input_conditioner: RTL and testbench

Front-end stage that sits directly upstream of the ATM controller FSM. It takes the three raw, bouncing push-buttons and the 4-bit slide switches from the board pins. It delivers synchronized, debounced, single-cycle button pulses (BTN3/BTN2/BTN1 priority preserved) and a synchronized switch value. This ensures each physical press advances the controller FSM exactly once.

---
 rtl/atm_input_conditioner.sv | 143 ++++++++++++++
 tb/tb_atm_input_conditioner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/atm_input_conditioner.sv
// Input front-end for the ATM controller: 2-FF synchronizers, per-button debounce FSMs,
// and registered one-cycle press pulses with BTN3 > BTN2 > BTN1 priority.
module atm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn3_raw,
    input  logic       btn2_raw,
    input  logic       btn1_raw,
    input  logic [3:0] sw_raw,
    output logic       BTN3,
    output logic       BTN2,
    output logic       BTN1,
    output logic [3:0] SW,
    output logic [2:0] held
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [2:0]       btn_meta;
    logic [2:0]       btn_sync;
    logic [3:0]       sw_meta;
    logic [3:0]       sw_sync;

    btn_state_t       state      [3];
    btn_state_t       state_next [3];
    logic [CNT_W-1:0] cnt        [3];
    logic [CNT_W-1:0] cnt_next   [3];
    logic [2:0]       cand;
    logic [2:0]       held_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= {btn3_raw, btn2_raw, btn1_raw};
            btn_sync <= btn_meta;
            sw_meta  <= sw_raw;
            sw_sync  <= sw_meta;
        end
    end

    assign SW = sw_sync;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (!rst) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end else begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
        end
    end

    // Counters only advance below CNT_MAX, so they saturate instead of wrapping.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            case (state[i])
                IDLE: begin
                    if (btn_sync[i]) begin
                        state_next[i] = PRESS_WAIT;
                        cnt_next[i]   = CNT_W'(1);
                    end else begin
                        cnt_next[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync[i]) begin
                        state_next[i] = IDLE;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        state_next[i] = HELD;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] < CNT_MAX) begin
                        cnt_next[i]   = cnt[i] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_sync[i]) begin
                        state_next[i] = RELEASE_WAIT;
                        cnt_next[i]   = CNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync[i]) begin
                        state_next[i] = HELD;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        state_next[i] = IDLE;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] < CNT_MAX) begin
                        cnt_next[i]   = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_next[i] = IDLE;
                    cnt_next[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        cand      = '0;
        held_next = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            cand[i]      = (state[i] == PRESS_WAIT) && (state_next[i] == HELD);
            held_next[i] = (state_next[i] == HELD) || (state_next[i] == RELEASE_WAIT);
        end
    end

    // Losing candidates are simply dropped; their FSMs still move to HELD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            BTN3 <= 1'b0;
            BTN2 <= 1'b0;
            BTN1 <= 1'b0;
            held <= '0;
        end else begin
            BTN3 <= cand[2];
            BTN2 <= cand[1] & ~cand[2];
            BTN1 <= cand[0] & ~cand[1] & ~cand[2];
            held <= held_next;
        end
    end

endmodule

// File: tb/tb_atm_input_conditioner.sv
// Scoreboard bench for atm_input_conditioner: stimulus queues expected pulses and
// level samples per cycle; a negedge monitor pops and compares them.
module tb_atm_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn3_raw = 1'b0;
    logic       btn2_raw = 1'b0;
    logic       btn1_raw = 1'b0;
    logic [3:0] sw_raw = 4'h0;
    logic       BTN3;
    logic       BTN2;
    logic       BTN1;
    logic [3:0] SW;
    logic [2:0] held;

    atm_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn3_raw(btn3_raw),
        .btn2_raw(btn2_raw),
        .btn1_raw(btn1_raw),
        .sw_raw(sw_raw),
        .BTN3(BTN3),
        .BTN2(BTN2),
        .BTN1(BTN1),
        .SW(SW),
        .held(held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] mask;
    } pulse_t;

    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] val;
    } lvl_t;

    pulse_t pq[$];
    lvl_t   lq[$];
    int     compared   = 0;
    int     mismatched = 0;

    task automatic exp_pulse(input int c, input logic [2:0] m);
        pq.push_back('{cyc: c, mask: m});
    endtask

    // kind 0: {BTN3,BTN2,BTN1}, kind 1: held, kind 2: SW
    task automatic exp_lvl(input int c, input int k, input logic [3:0] v);
        lq.push_back('{cyc: c, kind: k, val: v});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [2:0] mon_p;
    logic [3:0] mon_a;
    pulse_t     mon_e;

    always @(negedge clk) begin
        mon_p = {BTN3, BTN2, BTN1};
        if (mon_p != 3'b000) begin
            compared++;
            if (pq.size() == 0) begin
                mismatched++;
                $display("FAIL pulse_unexpected cyc=%0d got=%b expected none", cyc, mon_p);
            end else begin
                mon_e = pq.pop_front();
                if (mon_e.mask !== mon_p || mon_e.cyc != cyc) begin
                    mismatched++;
                    $display("FAIL pulse cyc=%0d got=%b required=%b at cyc %0d",
                             cyc, mon_p, mon_e.mask, mon_e.cyc);
                end
            end
        end else begin
            while (pq.size() > 0 && pq[0].cyc <= cyc) begin
                mon_e = pq.pop_front();
                compared++;
                mismatched++;
                $display("FAIL pulse_missing cyc=%0d got=000 required=%b", cyc, mon_e.mask);
            end
        end
        for (int i = lq.size() - 1; i >= 0; i--) begin
            if (lq[i].cyc == cyc) begin
                case (lq[i].kind)
                    0:       mon_a = {1'b0, BTN3, BTN2, BTN1};
                    1:       mon_a = {1'b0, held};
                    default: mon_a = SW;
                endcase
                compared++;
                if (mon_a !== lq[i].val) begin
                    mismatched++;
                    $display("FAIL level kind=%0d cyc=%0d got=%h required=%h",
                             lq[i].kind, cyc, mon_a, lq[i].val);
                end
                lq.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int t0, t1, tf;

    initial begin
        sw_raw = 4'h5;
        exp_lvl(3, 2, 4'h0);
        exp_lvl(4, 0, 4'h0);
        exp_lvl(4, 1, 4'h0);
        exp_lvl(4, 2, 4'h0);
        exp_lvl(5, 2, 4'h5);
        step(3);
        rst = 1'b1;
        step(3);

        // clean press on btn3
        t0 = cyc;
        btn3_raw = 1'b1;
        exp_pulse(t0 + 7, 3'b100);
        exp_lvl(t0 + 6, 1, 4'h0);
        exp_lvl(t0 + 7, 1, 4'h4);
        exp_lvl(t0 + 8, 0, 4'h0);
        step(20);
        t1 = cyc;
        btn3_raw = 1'b0;
        exp_lvl(t1 + 6, 1, 4'h4);
        exp_lvl(t1 + 7, 1, 4'h0);
        step(10);

        // bouncing btn2
        btn2_raw = 1'b1; step(1);
        btn2_raw = 1'b0; step(1);
        btn2_raw = 1'b1; step(1);
        btn2_raw = 1'b0; step(1);
        tf = cyc;
        btn2_raw = 1'b1;
        exp_lvl(tf + 3, 1, 4'h0);
        exp_lvl(tf + 6, 1, 4'h0);
        exp_pulse(tf + 7, 3'b010);
        exp_lvl(tf + 7, 1, 4'h2);
        step(12);
        btn2_raw = 1'b0;
        step(10);

        // short glitch on btn1
        t0 = cyc;
        btn1_raw = 1'b1;
        for (int k = 1; k <= 9; k++) exp_lvl(t0 + k, 1, 4'h0);
        step(3);
        btn1_raw = 1'b0;
        step(10);

        // simultaneous btn3 + btn1, then fresh btn1
        t0 = cyc;
        btn3_raw = 1'b1;
        btn1_raw = 1'b1;
        exp_pulse(t0 + 7, 3'b100);
        exp_lvl(t0 + 7, 1, 4'h5);
        step(10);
        t1 = cyc;
        btn3_raw = 1'b0;
        btn1_raw = 1'b0;
        exp_lvl(t1 + 6, 1, 4'h5);
        exp_lvl(t1 + 7, 1, 4'h0);
        step(10);
        t0 = cyc;
        btn1_raw = 1'b1;
        exp_pulse(t0 + 7, 3'b001);
        exp_lvl(t0 + 7, 1, 4'h1);
        step(10);
        btn1_raw = 1'b0;
        step(10);

        // reset in the middle of a btn3 debounce, then switch path
        t0 = cyc;
        btn3_raw = 1'b1;
        exp_lvl(t0 + 5, 1, 4'h0);
        exp_lvl(t0 + 5, 2, 4'h0);
        exp_lvl(t0 + 6, 2, 4'h0);
        exp_lvl(t0 + 7, 2, 4'h5);
        exp_lvl(t0 + 11, 1, 4'h0);
        exp_pulse(t0 + 12, 3'b100);
        exp_lvl(t0 + 12, 1, 4'h4);
        step(4);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(10);
        t1 = cyc;
        sw_raw = 4'hA;
        exp_lvl(t1 + 1, 2, 4'h5);
        exp_lvl(t1 + 2, 2, 4'hA);
        step(4);
        btn3_raw = 1'b0;
        step(12);

        while (pq.size() > 0) begin
            mon_e = pq.pop_front();
            compared++;
            mismatched++;
            $display("FAIL pulse_never_seen got=none required=%b at cyc %0d", mon_e.mask, mon_e.cyc);
        end
        while (lq.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL level_never_sampled kind=%0d cyc=%0d got=none required=%h",
                     lq[0].kind, lq[0].cyc, lq[0].val);
            lq.delete(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
